// File: rtl/cube_move_scheduler_if.sv
// Move request / dispatch signal bundle for cube_move_scheduler.
// master drives requests and busy; slave is the scheduler side.
interface cube_move_scheduler_if;
  logic       I_btn_req;
  logic [3:0] I_btn_mode;
  logic [1:0] I_btn_num;
  logic       I_bt_req;
  logic [3:0] I_bt_mode;
  logic [1:0] I_bt_num;
  logic       I_scramble;
  logic       I_cube_busy;
  logic       O_act;
  logic [3:0] O_mode;
  logic [1:0] O_num;
  logic       O_full;
  logic       O_drop;
  logic       O_scrambling;

  modport master (
    output I_btn_req, I_btn_mode, I_btn_num,
    output I_bt_req, I_bt_mode, I_bt_num,
    output I_scramble, I_cube_busy,
    input  O_act, O_mode, O_num, O_full, O_drop, O_scrambling
  );

  modport slave (
    input  I_btn_req, I_btn_mode, I_btn_num,
    input  I_bt_req, I_bt_mode, I_bt_num,
    input  I_scramble, I_cube_busy,
    output O_act, O_mode, O_num, O_full, O_drop, O_scrambling
  );
endinterface

// File: rtl/cube_move_scheduler.sv
// Buffers button/bluetooth cube moves in a FIFO and dispatches them with a
// minimum spacing; can also generate an LFSR-driven scramble sequence.
module cube_move_scheduler #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned GAP     = 1000,
  parameter int unsigned SCR_LEN = 20
) (
  input  logic                 clk,
  input  logic                 I_rst,
  cube_move_scheduler_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned MW = 8;

  typedef struct packed {
    logic [2:0] mode;
    logic [1:0] num;
  } move_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state_q, state_d;
  move_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q;
  logic [GW-1:0] gap_q;
  logic [MW-1:0] mv_cnt_q;
  logic          scr_q;
  logic          src_scr_q;
  logic [15:0]   lfsr_q;
  logic          act_q;
  logic          drop_q;
  move_t         cur_q;

  logic  wr_en, pop, drop_n, scr_go, issue_go, lfsr_fb;
  move_t wr_data, scr_move;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Request arbitration: button beats bluetooth, one write per cycle.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    drop_n  = 1'b0;
    scr_go  = 1'b0;
    pop     = (state_q == S_ISSUE) && !src_scr_q;
    if (bus.I_btn_req) begin
      if (bus.I_btn_mode[3] || scr_q || (full_q && !pop)) begin
        drop_n = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_data = '{mode: bus.I_btn_mode[2:0], num: bus.I_btn_num};
      end
      if (bus.I_bt_req) drop_n = 1'b1;
    end else if (bus.I_bt_req) begin
      if (bus.I_bt_mode[3] || scr_q || (full_q && !pop)) begin
        drop_n = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_data = '{mode: bus.I_bt_mode[2:0], num: bus.I_bt_num};
      end
    end
    if (bus.I_scramble) begin
      if (count_q == '0 && !scr_q) scr_go = 1'b1;
      else                         drop_n = 1'b1;
    end
    count_d = count_q + CW'(wr_en) - CW'(pop);
  end

  // Scramble move: never repeat the previously issued face.
  always_comb begin
    scr_move.mode = lfsr_q[2:0];
    if (lfsr_q[2:0] == cur_q.mode) scr_move.mode = lfsr_q[2:0] + 3'd1;
    scr_move.num = (lfsr_q[4:3] == 2'd0) ? 2'd1 : lfsr_q[4:3];
  end

  // Dispatch FSM next state.
  always_comb begin
    state_d  = state_q;
    issue_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0 || scr_q) begin
          state_d  = S_ISSUE;
          issue_go = 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (gap_q == '0 && !bus.I_cube_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (I_rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      gap_q     <= '0;
      mv_cnt_q  <= '0;
      scr_q     <= 1'b0;
      src_scr_q <= 1'b0;
      lfsr_q    <= 16'hACE1;
      act_q     <= 1'b0;
      drop_q    <= 1'b0;
      cur_q     <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
      act_q   <= issue_go;
      drop_q  <= drop_n;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      if (issue_go) begin
        src_scr_q <= scr_q;
        cur_q     <= scr_q ? scr_move : mem[rd_ptr_q];
      end
      if (state_q == S_ISSUE)                    gap_q <= GW'(GAP - 1);
      else if (state_q == S_WAIT && gap_q != '0) gap_q <= gap_q - GW'(1);
      // The scramble flag drops right after the ISSUE of the final move.
      if (scr_go) begin
        scr_q    <= 1'b1;
        mv_cnt_q <= MW'(SCR_LEN);
      end else if (state_q == S_ISSUE && src_scr_q) begin
        mv_cnt_q <= mv_cnt_q - MW'(1);
        if (mv_cnt_q == MW'(1)) scr_q <= 1'b0;
      end
    end
  end

  // A strobe never escapes in a cycle where reset is held.
  assign bus.O_act        = act_q & ~I_rst;
  assign bus.O_mode       = {1'b0, cur_q.mode};
  assign bus.O_num        = cur_q.num;
  assign bus.O_full       = full_q;
  assign bus.O_drop       = drop_q;
  assign bus.O_scrambling = scr_q;
endmodule

// File: tb/tb_cube_move_scheduler.sv
// Directed + randomized bench for cube_move_scheduler with a queue-based
// reference model of FIFO acceptance, ordering and scramble properties.
module tb_cube_move_scheduler;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned GAP     = 16;
  localparam int unsigned SCR_LEN = 20;

  logic clk = 1'b0;
  logic I_rst;
  cube_move_scheduler_if bus();

  cube_move_scheduler #(.DEPTH(DEPTH), .GAP(GAP), .SCR_LEN(SCR_LEN)) dut (
    .clk(clk), .I_rst(I_rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_act_cyc = 0;
  logic have_last = 1'b0;
  logic last_act_scr = 1'b0;
  logic [3:0] last_mode = 4'd0;
  logic [5:0] obs_q[$];
  logic [5:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle and record any dispatched move.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.O_act === 1'b1) begin
      if (have_last) chk("act_spacing_ge_gap", 32'(cyc - last_act_cyc >= int'(GAP)), 32'd1);
      obs_q.push_back({bus.O_mode, bus.O_num});
      last_act_cyc = cyc;
      have_last    = 1'b1;
      last_act_scr = bus.O_scrambling;
      last_mode    = bus.O_mode;
    end
  endtask

  task automatic clear_reqs();
    bus.I_btn_req  = 1'b0;
    bus.I_bt_req   = 1'b0;
    bus.I_scramble = 1'b0;
  endtask

  task automatic set_btn(input logic [3:0] m, input logic [1:0] n);
    bus.I_btn_req = 1'b1; bus.I_btn_mode = m; bus.I_btn_num = n;
  endtask

  task automatic set_bt(input logic [3:0] m, input logic [1:0] n);
    bus.I_bt_req = 1'b1; bus.I_bt_mode = m; bus.I_bt_num = n;
  endtask

  // Wait for n moves (bounded) and compare them in order to the model queue.
  task automatic drain(input int n);
    int k = 0;
    int budget = (n + 1) * (int'(GAP) + 8) + 20;
    while (obs_q.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("drain_count", 32'(obs_q.size()), 32'(n));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk("move_order", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic quiet(input int n);
    obs_q.delete();
    repeat (n) step();
    chk("no_spurious_act", 32'(obs_q.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int occ, n, got, k;
    logic use_btn, use_bt, exp_drop;
    logic [3:0] bm, tm, prev;
    logic [1:0] bn, tn;
    logic [5:0] m;

    clear_reqs();
    bus.I_btn_mode = '0; bus.I_btn_num = '0;
    bus.I_bt_mode = '0;  bus.I_bt_num = '0;
    bus.I_cube_busy = 1'b0;
    I_rst = 1'b1;
    step(); step();
    chk("rst_act", bus.O_act, 0);
    chk("rst_drop", bus.O_drop, 0);
    chk("rst_full", bus.O_full, 0);
    chk("rst_scrambling", bus.O_scrambling, 0);
    chk("rst_mode", bus.O_mode, 0);
    chk("rst_num", bus.O_num, 0);
    I_rst = 1'b0;
    step();

    // Two-cycle latency into an idle, empty block.
    set_btn(4'd2, 2'd1);
    step();
    chk("lat_write_cycle_act", bus.O_act, 0);
    clear_reqs();
    step();
    chk("lat_issue_act", bus.O_act, 1);
    chk("lat_issue_mode", bus.O_mode, 2);
    chk("lat_issue_num", bus.O_num, 1);
    obs_q.delete();
    set_btn(4'd7, 2'd0);
    exp_q.push_back({4'd7, 2'd0});
    step();
    clear_reqs();
    chk("act_one_cycle", bus.O_act, 0);
    chk("mode_hold", bus.O_mode, 2);
    drain(1);
    quiet(GAP + 4);

    // Simultaneous button and bluetooth: button wins, bluetooth dropped.
    set_btn(4'd5, 2'd3);
    set_bt(4'd6, 2'd2);
    exp_q.push_back({4'd5, 2'd3});
    step();
    clear_reqs();
    chk("both_drop", bus.O_drop, 1);
    step();
    chk("both_drop_one_cycle", bus.O_drop, 0);
    drain(1);
    quiet(GAP + 4);

    // Invalid move codes.
    set_btn(4'b1001, 2'd1);
    step();
    clear_reqs();
    chk("bad_btn_drop", bus.O_drop, 1);
    set_bt(4'hF, 2'd2);
    step();
    clear_reqs();
    chk("bad_bt_drop", bus.O_drop, 1);
    quiet(3 * GAP);

    // Randomized bursts against a stalled dispatcher, round 0 is the overflow case.
    for (int r = 0; r < 6; r++) begin
      quiet(GAP + 4);
      bus.I_cube_busy = 1'b1;
      set_btn(4'(r % 8), 2'd1);
      exp_q.push_back({4'(r % 8), 2'd1});
      step();
      clear_reqs();
      drain(1);
      occ = 0;
      n = (r == 0) ? 9 : int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        use_btn = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        use_bt  = (r == 0) ? 1'b0 : (use_btn ? ($urandom_range(0, 3) == 0) : 1'b1);
        bm = (r == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 9));
        tm = 4'($urandom_range(0, 9));
        bn = 2'($urandom_range(0, 3));
        tn = 2'($urandom_range(0, 3));
        if (use_btn) set_btn(bm, bn);
        if (use_bt)  set_bt(tm, tn);
        exp_drop = use_btn && use_bt;
        if (use_btn) begin
          if (bm[3] || occ == int'(DEPTH)) exp_drop = 1'b1;
          else begin exp_q.push_back({bm, bn}); occ++; end
        end else begin
          if (tm[3] || occ == int'(DEPTH)) exp_drop = 1'b1;
          else begin exp_q.push_back({tm, tn}); occ++; end
        end
        step();
        clear_reqs();
        chk("rnd_drop", bus.O_drop, 32'(exp_drop));
        chk("rnd_full", bus.O_full, 32'(occ == int'(DEPTH)));
      end
      bus.I_cube_busy = 1'b0;
      drain(occ);
    end

    // Scramble refused while the FIFO holds a move.
    quiet(GAP + 4);
    bus.I_cube_busy = 1'b1;
    set_btn(4'd1, 2'd1);
    exp_q.push_back({4'd1, 2'd1});
    step();
    clear_reqs();
    drain(1);
    set_btn(4'd3, 2'd2);
    exp_q.push_back({4'd3, 2'd2});
    step();
    clear_reqs();
    bus.I_scramble = 1'b1;
    step();
    clear_reqs();
    chk("scr_busy_fifo_drop", bus.O_drop, 1);
    chk("scr_busy_fifo_not_started", bus.O_scrambling, 0);
    bus.I_cube_busy = 1'b0;
    drain(1);
    quiet(GAP + 4);

    // Full scramble: SCR_LEN moves, no repeated face, non-zero amounts.
    obs_q.delete();
    prev = last_mode;
    bus.I_scramble = 1'b1;
    step();
    clear_reqs();
    chk("scr_accept_no_drop", bus.O_drop, 0);
    chk("scr_flag_set", bus.O_scrambling, 1);
    set_btn(4'd4, 2'd1);
    step();
    clear_reqs();
    chk("scr_btn_drop", bus.O_drop, 1);
    bus.I_scramble = 1'b1;
    step();
    clear_reqs();
    chk("scr_again_drop", bus.O_drop, 1);
    set_bt(4'd2, 2'd2);
    step();
    clear_reqs();
    chk("scr_bt_drop", bus.O_drop, 1);
    got = 0;
    k = 0;
    while (got < int'(SCR_LEN) && k < int'(SCR_LEN + 2) * (int'(GAP) + 8)) begin
      if (obs_q.size() == 0) begin
        step();
        k++;
      end
      while (obs_q.size() > 0 && got < int'(SCR_LEN)) begin
        m = obs_q.pop_front();
        chk("scr_num_nonzero", 32'(m[1:0] != 2'd0), 32'd1);
        chk("scr_mode_changes", 32'(m[5:2] != prev), 32'd1);
        chk("scr_mode_valid", 32'(m[5]), 32'd0);
        prev = m[5:2];
        got++;
      end
    end
    chk("scr_move_count", 32'(got), 32'(SCR_LEN));
    chk("scr_flag_on_last_issue", 32'(last_act_scr), 32'd1);
    step();
    chk("scr_flag_cleared", bus.O_scrambling, 0);
    quiet(3 * GAP);

    // Reset in the middle of a scramble, landing on an issue cycle.
    bus.I_scramble = 1'b1;
    step();
    clear_reqs();
    got = 0;
    k = 0;
    while (got < 3 && k < 5 * (int'(GAP) + 8)) begin
      step();
      k++;
      got = obs_q.size();
    end
    chk("rst_mid_scr_reached", 32'(got), 32'd3);
    I_rst = 1'b1;
    #1;
    chk("rst_gates_act", bus.O_act, 0);
    step();
    chk("rst_mid_scr_flag", bus.O_scrambling, 0);
    chk("rst_mid_scr_full", bus.O_full, 0);
    chk("rst_mid_scr_act", bus.O_act, 0);
    I_rst = 1'b0;
    quiet(3 * GAP);
    set_btn(4'd6, 2'd3);
    exp_q.push_back({4'd6, 2'd3});
    step();
    clear_reqs();
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
